bus_access_scheduler: RTL

Tracks I3C bus availability from the bus monitor's START/STOP detections and raw line levels, then grants bus ownership to one of two local requesters. Requester 0 is the controller transaction FSM and needs Bus Free. Requester 1 is the target IBI/Hot-Join engine and needs Bus Available. Sits between the bus monitor and the controller/target FSMs in the controller top, and is the only source of "may drive START" permission.

---
 rtl/bus_access_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bus_access_scheduler.sv
// ============================================================================
// bus_access_scheduler: I3C bus-availability tracker and two-requester arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module bus_access_scheduler #(
  parameter int unsigned CntW = 20
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            scl_i,
  input  logic            sda_i,
  input  logic            start_detect_i,
  input  logic            stop_detect_i,
  input  logic [CntW-1:0] t_bus_free_i,
  input  logic [CntW-1:0] t_bus_avail_i,
  input  logic [CntW-1:0] t_bus_idle_i,
  input  logic [1:0]      req_i,
  input  logic [1:0]      release_i,
  output logic [1:0]      gnt_o,
  output logic [1:0]      bus_state_o,
  output logic            bus_free_o,
  output logic            bus_avail_o,
  output logic            bus_idle_o
);

  typedef enum logic [1:0] {
    BUSY  = 2'd0,
    FREE  = 2'd1,
    AVAIL = 2'd2,
    IDLE  = 2'd3
  } bus_state_e;

  // Grant states are one-hot so the state register doubles as gnt_o.
  typedef enum logic [1:0] {
    G_NONE = 2'b00,
    G0     = 2'b01,
    G1     = 2'b10
  } gnt_state_e;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stopped_q, stopped_d;
  bus_state_e      bus_state_q, bus_state_d;
  gnt_state_e      gnt_state_q, gnt_state_d;
  logic            last_q, last_d;
  logic            elig0, elig1;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || start_detect_i || stop_detect_i || !scl_i || !sda_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Long-enough high lines imply a STOP we never saw (e.g. after reset).
  always_comb begin
    stopped_d = stopped_q;
    if (!enable_i || start_detect_i) begin
      stopped_d = 1'b0;
    end else if (stop_detect_i || (cnt_q >= t_bus_idle_i)) begin
      stopped_d = 1'b1;
    end
  end

  always_comb begin
    bus_state_d = BUSY;
    if (!enable_i || start_detect_i)    bus_state_d = BUSY;
    else if (!stopped_q)                bus_state_d = BUSY;
    else if (cnt_q >= t_bus_idle_i)     bus_state_d = IDLE;
    else if (cnt_q >= t_bus_avail_i)    bus_state_d = AVAIL;
    else if (cnt_q >= t_bus_free_i)     bus_state_d = FREE;
    else                                bus_state_d = BUSY;
  end

  assign elig0 = req_i[0] && (bus_state_q >= FREE);
  assign elig1 = req_i[1] && (bus_state_q >= AVAIL);

  always_comb begin
    gnt_state_d = gnt_state_q;
    last_d      = last_q;
    if (!enable_i) begin
      gnt_state_d = G_NONE;
      last_d      = 1'b1;
    end else begin
      case (gnt_state_q)
        G_NONE: begin
          if (!start_detect_i) begin
            if (elig0 && (!elig1 || last_q)) begin
              gnt_state_d = G0;
              last_d      = 1'b0;
            end else if (elig1) begin
              gnt_state_d = G1;
              last_d      = 1'b1;
            end
          end
        end
        G0:      if (release_i[0]) gnt_state_d = G_NONE;
        G1:      if (release_i[1]) gnt_state_d = G_NONE;
        default: gnt_state_d = G_NONE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      stopped_q   <= 1'b0;
      bus_state_q <= BUSY;
      gnt_state_q <= G_NONE;
      last_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      stopped_q   <= stopped_d;
      bus_state_q <= bus_state_d;
      gnt_state_q <= gnt_state_d;
      last_q      <= last_d;
    end
  end

  assign gnt_o       = gnt_state_q;
  assign bus_state_o = bus_state_q;
  assign bus_free_o  = (bus_state_q != BUSY);
  assign bus_avail_o = (bus_state_q >= AVAIL);
  assign bus_idle_o  = (bus_state_q == IDLE);

endmodule

`default_nettype wire
